// File: rtl/jump_pkg.sv
// Shared encodings for the jump controller: branch condition codes and FSM states.
package jump_pkg;

   typedef enum logic [3:0] {
      COND_ALWAYS = 4'd0,
      COND_Z      = 4'd1,
      COND_NZ     = 4'd2,
      COND_LT     = 4'd3,
      COND_LE     = 4'd4,
      COND_GT     = 4'd5,
      COND_GE     = 4'd6,
      COND_C      = 4'd7,
      COND_NC     = 4'd8,
      COND_BE     = 4'd9,
      COND_A      = 4'd10,
      COND_O      = 4'd11,
      COND_NO     = 4'd12,
      COND_S      = 4'd13,
      COND_NS     = 4'd14,
      COND_NEVER  = 4'd15
   } cond_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SKIP   = 3'd1,
      FETCH0 = 3'd2,
      FETCH1 = 3'd3,
      LOAD   = 3'd4
   } state_e;

endpackage

// File: rtl/jump_ctrl_if.sv
// Decoder, flag-register, memory and PC signals of the jump controller.
// The controller itself uses the slave modport; its environment uses master.
interface jump_ctrl_if #(parameter int ADDR_W = 16);
   logic              start;
   logic [3:0]        cond;
   logic              zflag;
   logic              oflag;
   logic              cflag;
   logic              sflag;
   logic [ADDR_W-1:0] pc_in;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              mem_valid;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_next;
   logic              taken;
   logic              busy;

   modport master (
      output start, cond, zflag, oflag, cflag, sflag, pc_in, mem_rdata, mem_valid,
      input  mem_req, mem_addr, pc_load, pc_next, taken, busy
   );

   modport slave (
      input  start, cond, zflag, oflag, cflag, sflag, pc_in, mem_rdata, mem_valid,
      output mem_req, mem_addr, pc_load, pc_next, taken, busy
   );
endinterface

// File: rtl/jump_cond.sv
// Combinational branch-condition evaluator: condition code plus Z/O/C/S flags to taken.
// Shared with the conditional-move path, so it carries no state.
module jump_cond
   import jump_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic       i_zflag,
   input  logic       i_oflag,
   input  logic       i_cflag,
   input  logic       i_sflag,
   output logic       o_taken
);

   logic w_lt;

   always_comb begin
      w_lt    = i_sflag ^ i_oflag;
      o_taken = 1'b0;
      case (cond_e'(i_cond))
         COND_ALWAYS: o_taken = 1'b1;
         COND_Z:      o_taken = i_zflag;
         COND_NZ:     o_taken = ~i_zflag;
         COND_LT:     o_taken = w_lt;
         COND_LE:     o_taken = i_zflag | w_lt;
         COND_GT:     o_taken = ~i_zflag & ~w_lt;
         COND_GE:     o_taken = ~w_lt;
         COND_C:      o_taken = i_cflag;
         COND_NC:     o_taken = ~i_cflag;
         COND_BE:     o_taken = i_cflag | i_zflag;
         COND_A:      o_taken = ~i_cflag & ~i_zflag;
         COND_O:      o_taken = i_oflag;
         COND_NO:     o_taken = ~i_oflag;
         COND_S:      o_taken = i_sflag;
         COND_NS:     o_taken = ~i_sflag;
         COND_NEVER:  o_taken = 1'b0;
         default:     o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/jump_ctrl.sv
// Conditional jump sequencer: evaluates the condition at start, then either skips the operand
// or fetches a 2-byte absolute target over req/valid and loads the PC.
module jump_ctrl
   import jump_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter bit HI_FIRST = 1'b1
)(
   input  logic        clk,
   input  logic        rst_n,
   jump_ctrl_if.slave  bus
);

   state_e            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [7:0]        r_byte0;
   logic              w_taken;
   logic [ADDR_W-1:0] w_target;

   // Flags and cond are evaluated straight off the inputs; the result is latched on start,
   // which is equivalent to latching the operands and evaluating later.
   jump_cond u_cond (
      .i_cond  (bus.cond),
      .i_zflag (bus.zflag),
      .i_oflag (bus.oflag),
      .i_cflag (bus.cflag),
      .i_sflag (bus.sflag),
      .o_taken (w_taken)
   );

   // The second byte is used straight from the bus so LOAD follows FETCH1 with no extra cycle.
   always_comb begin
      w_target = HI_FIRST ? ADDR_W'({r_byte0, bus.mem_rdata})
                          : ADDR_W'({bus.mem_rdata, r_byte0});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_pc         <= '0;
         r_byte0      <= '0;
         bus.mem_req  <= 1'b0;
         bus.mem_addr <= '0;
         bus.pc_load  <= 1'b0;
         bus.pc_next  <= '0;
         bus.taken    <= 1'b0;
         bus.busy     <= 1'b0;
      end else begin
         bus.pc_load <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_pc      <= bus.pc_in;
                  bus.taken <= w_taken;
                  bus.busy  <= 1'b1;
                  if (w_taken) begin
                     r_state      <= FETCH0;
                     bus.mem_req  <= 1'b1;
                     bus.mem_addr <= bus.pc_in;
                  end else begin
                     r_state     <= SKIP;
                     bus.pc_load <= 1'b1;
                     bus.pc_next <= bus.pc_in + ADDR_W'(2);
                  end
               end
            end
            SKIP: begin
               r_state  <= IDLE;
               bus.busy <= 1'b0;
            end
            FETCH0: begin
               if (bus.mem_valid) begin
                  r_byte0      <= bus.mem_rdata;
                  bus.mem_addr <= r_pc + ADDR_W'(1);
                  r_state      <= FETCH1;
               end
            end
            FETCH1: begin
               if (bus.mem_valid) begin
                  bus.mem_req <= 1'b0;
                  bus.pc_load <= 1'b1;
                  bus.pc_next <= w_target;
                  r_state     <= LOAD;
               end
            end
            LOAD: begin
               r_state  <= IDLE;
               bus.busy <= 1'b0;
            end
            default: begin
               r_state     <= IDLE;
               bus.mem_req <= 1'b0;
               bus.busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl: expected PC loads and fetch addresses are queued at stimulus
// time and compared when the DUT issues pc_load / completes memory reads.
module tb_jump_ctrl;
   import jump_pkg::*;

   localparam int ADDR_W = 16;

   typedef struct {
      logic        tk;
      logic [15:0] pc;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jump_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   jump_ctrl #(.ADDR_W(ADDR_W), .HI_FIRST(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t        exp_q[$];
   logic [15:0] addr_q[$];
   logic [7:0]  mem [logic [15:0]];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cyc = 0;
   int wait_cfg = 0;
   bit mem_force = 1'b0;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   function automatic logic model_cond(input logic [3:0] c, input logic z, o, cf, s);
      case (c)
         4'd0:  return 1'b1;
         4'd1:  return z;
         4'd2:  return !z;
         4'd3:  return s != o;
         4'd4:  return z || (s != o);
         4'd5:  return !z && (s == o);
         4'd6:  return s == o;
         4'd7:  return cf;
         4'd8:  return !cf;
         4'd9:  return cf || z;
         4'd10: return !cf && !z;
         4'd11: return o;
         4'd12: return !o;
         4'd13: return s;
         4'd14: return !s;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: answers after wait_cfg stall cycles and checks fetch addresses.
   initial begin
      int          wcnt;
      bit          stalled;
      logic [15:0] prev_addr;
      wcnt = 0;
      stalled = 1'b0;
      prev_addr = '0;
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (mem_force) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = 8'hEE;
            stalled = 1'b0;
            wcnt = 0;
         end else if (bus.mem_req && addr_q.size() == 0) begin
            chk_eq("unexpected_mem_req", bus.mem_req, 1'b0);
            bus.mem_valid = 1'b0;
         end else if (bus.mem_req) begin
            if (stalled) chk_eq("addr_stable", bus.mem_addr, prev_addr);
            if (wcnt >= wait_cfg) begin
               bus.mem_valid = 1'b1;
               bus.mem_rdata = mem_byte(bus.mem_addr);
               chk_eq("fetch_addr", bus.mem_addr, addr_q.pop_front());
               wcnt = 0;
               stalled = 1'b0;
            end else begin
               bus.mem_valid = 1'b0;
               prev_addr = bus.mem_addr;
               stalled = 1'b1;
               wcnt++;
            end
         end else begin
            bus.mem_valid = 1'b0;
            wcnt = 0;
            stalled = 1'b0;
         end
      end
   end

   // PC-load monitor: pops the scoreboard on every pc_load.
   initial begin
      exp_t e;
      bit   idle_due;
      idle_due = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (idle_due) begin
            chk_eq("busy_after_load", bus.busy, 1'b0);
            idle_due = 1'b0;
         end
         if (bus.pc_load) begin
            if (exp_q.size() == 0) begin
               chk_eq("unexpected_pc_load", bus.pc_load, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk_eq("pc_next", bus.pc_next, e.pc);
               chk_eq("taken", bus.taken, e.tk);
               chk_eq("latency", cyc - start_cyc, e.lat);
               chk_eq("busy_at_load", bus.busy, 1'b1);
               idle_due = 1'b1;
            end
         end
      end
   end

   task automatic do_jump(input logic [3:0] c, input logic [3:0] f, input logic [15:0] pc,
                          input int waits, input bit disturb);
      exp_t e;
      logic tk;
      wait_cfg = waits;
      tk = model_cond(c, f[3], f[2], f[1], f[0]);
      e.tk  = tk;
      e.pc  = tk ? {mem_byte(pc), mem_byte(pc + 16'd1)} : pc + 16'd2;
      e.lat = tk ? 3 + 2 * waits : 1;
      if (tk) begin
         addr_q.push_back(pc);
         addr_q.push_back(pc + 16'd1);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #2;
      bus.start = 1'b1;
      bus.cond  = c;
      {bus.zflag, bus.oflag, bus.cflag, bus.sflag} = f;
      bus.pc_in = pc;
      start_cyc = cyc;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      bus.pc_in = ~pc;
      bus.cond  = ~c;
      {bus.zflag, bus.oflag, bus.cflag, bus.sflag} = 4'($urandom);
      if (disturb) begin
         repeat (2) @(posedge clk);
         #2;
         bus.zflag = ~bus.zflag;
         bus.start = 1'b1;
         bus.pc_in = 16'h5555;
         bus.cond  = COND_NEVER;
         @(posedge clk);
         #2;
         bus.start = 1'b0;
         bus.zflag = ~bus.zflag;
      end
      for (int i = 0; i < 60 && (exp_q.size() != 0 || bus.busy); i++) begin
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         chk_eq("jump_timeout", exp_q.size(), 0);
         exp_q.delete();
         addr_q.delete();
      end
      repeat (disturb ? 4 : 1) @(posedge clk);
      #2;
      chk_eq("taken_held", bus.taken, tk);
      chk_eq("pc_next_held", bus.pc_next, e.pc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.cond  = 4'd0;
      {bus.zflag, bus.oflag, bus.cflag, bus.sflag} = 4'b0000;
      bus.pc_in = '0;
      repeat (3) @(posedge clk);
      #2;
      chk_eq("rst_mem_req", bus.mem_req, 1'b0);
      chk_eq("rst_mem_addr", bus.mem_addr, 16'h0000);
      chk_eq("rst_pc_load", bus.pc_load, 1'b0);
      chk_eq("rst_pc_next", bus.pc_next, 16'h0000);
      chk_eq("rst_taken", bus.taken, 1'b0);
      chk_eq("rst_busy", bus.busy, 1'b0);
      rst_n = 1'b1;

      mem[16'h1234] = 8'hAB;
      mem[16'h1235] = 8'hCD;
      do_jump(4'd0, 4'b0000, 16'h1234, 0, 1'b0);
      do_jump(4'd1, 4'b0000, 16'h0100, 0, 1'b0);

      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            do_jump(4'(c), 4'(f), 16'($urandom), int'($urandom_range(0, 1)), 1'b0);
         end
      end

      do_jump(4'd1, 4'b1000, 16'h4000, 3, 1'b1);

      do_jump(4'd0, 4'b0000, 16'hFFFF, 0, 1'b0);
      do_jump(4'd15, 4'b0000, 16'hFFFF, 0, 1'b0);

      // Reset lands while FETCH1 sees mem_valid=1; no PC load may follow.
      wait_cfg = 0;
      addr_q.push_back(16'h2000);
      addr_q.push_back(16'h2001);
      @(posedge clk);
      #2;
      bus.start = 1'b1;
      bus.cond  = 4'd0;
      bus.pc_in = 16'h2000;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      @(posedge clk);
      #2;
      chk_eq("pre_rst_mem_addr", bus.mem_addr, 16'h2001);
      rst_n = 1'b0;
      mem_force = 1'b1;
      @(posedge clk);
      #2;
      chk_eq("midrst_mem_req", bus.mem_req, 1'b0);
      chk_eq("midrst_mem_addr", bus.mem_addr, 16'h0000);
      chk_eq("midrst_pc_load", bus.pc_load, 1'b0);
      chk_eq("midrst_pc_next", bus.pc_next, 16'h0000);
      chk_eq("midrst_taken", bus.taken, 1'b0);
      chk_eq("midrst_busy", bus.busy, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      mem_force = 1'b0;
      chk_eq("post_rst_busy", bus.busy, 1'b0);
      chk_eq("post_rst_pc_next", bus.pc_next, 16'h0000);
      chk_eq("post_rst_addr_q", addr_q.size(), 0);

      do_jump(4'd2, 4'b0000, 16'h0F00, 1, 1'b0);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
